// File: rtl/id_pkg.sv
// ============================================================================
// id_pkg -- MIPS-I opcode/funct/REGIMM codes, ALU codes, decode flag bundle. Rev 1.0
// ============================================================================
`default_nettype none

package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_LL      = 6'b110000;
    localparam logic [5:0] OP_SC      = 6'b111000;

    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SLLV    = 6'b000100;
    localparam logic [5:0] F_SRLV    = 6'b000110;
    localparam logic [5:0] F_SRAV    = 6'b000111;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_JALR    = 6'b001001;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    localparam logic [4:0] RI_BLTZ   = 5'b00000;
    localparam logic [4:0] RI_BGEZ   = 5'b00001;
    localparam logic [4:0] RI_BLTZAL = 5'b10000;
    localparam logic [4:0] RI_BGEZAL = 5'b10001;

    localparam logic [5:0] ALU_NOP     = 6'b000000;
    localparam logic [5:0] ALU_SYSCALL = 6'b001100;
    localparam logic [5:0] ALU_LUI     = 6'b001111;
    localparam logic [5:0] ALU_ADD     = 6'b100000;
    localparam logic [5:0] ALU_ADDU    = 6'b100001;
    localparam logic [5:0] ALU_AND     = 6'b100100;
    localparam logic [5:0] ALU_OR      = 6'b100101;
    localparam logic [5:0] ALU_XOR     = 6'b100110;
    localparam logic [5:0] ALU_SLT     = 6'b101010;
    localparam logic [5:0] ALU_SLTU    = 6'b101011;
    localparam logic [5:0] ALU_LL      = 6'b101000;
    localparam logic [5:0] ALU_SC      = 6'b110110;

    typedef struct packed {
        logic link;
        logic reg_dest;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic jump_register;
        logic sign_or_zero;
        logic syscall;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// id_regfile -- 32x32 register file, three read ports with write-through. Rev 1.0
// ============================================================================
`default_nettype none

module id_regfile (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] rd_data
);

    logic [31:0] regs [32];
    logic        wr_live;

    assign wr_live = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A write landing this cycle is visible to the reader immediately.
    assign rs_data = (rs_addr == 5'd0)                  ? 32'd0   :
                     (wr_live && wr_addr == rs_addr)    ? wr_data : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0)                  ? 32'd0   :
                     (wr_live && wr_addr == rt_addr)    ? wr_data : regs[rt_addr];
    assign rd_data = (rd_addr == 5'd0)                  ? 32'd0   :
                     (wr_live && wr_addr == rd_addr)    ? wr_data : regs[rd_addr];

endmodule

`default_nettype wire

// File: rtl/id_decode_unit.sv
// ============================================================================
// id_decode_unit -- MIPS-I decode, branch/jump target and register file. Rev 1.0
// ============================================================================
`default_nettype none

module id_decode_unit
    import id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] Instr_PC_Plus4,
    input  logic [31:0] JumpRegValue,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        Write,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [31:0] DataC,
    output logic [4:0]  DestReg,
    output logic [31:0] NextInstructionAddress,
    output logic        Link,
    output logic        RegDest,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        JumpRegister,
    output logic        SignOrZero,
    output logic        Syscall,
    output logic [5:0]  ALUControl
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    ctrl_t       ctrl;
    logic [5:0]  alu;

    assign opcode = Instr[31:26];
    assign rs     = Instr[25:21];
    assign rt     = Instr[20:16];
    assign rd     = Instr[15:11];
    assign funct  = Instr[5:0];
    assign imm    = Instr[15:0];

    always_comb begin
        ctrl = '0;
        alu  = ALU_NOP;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                        ctrl.reg_dest  = 1'b1;
                        ctrl.reg_write = 1'b1;
                        alu            = funct;
                    end
                    F_JR, F_JALR: begin
                        ctrl.jump          = 1'b1;
                        ctrl.jump_register = 1'b1;
                        ctrl.branch        = 1'b1;
                        ctrl.link          = (funct == F_JALR);
                        ctrl.reg_dest      = (funct == F_JALR);
                        ctrl.reg_write     = (funct == F_JALR);
                        alu                = ALU_ADDU;
                    end
                    F_SYSCALL: begin
                        ctrl.syscall = 1'b1;
                        alu          = ALU_SYSCALL;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RI_BLTZ, RI_BGEZ, RI_BLTZAL, RI_BGEZAL: begin
                        ctrl.branch    = 1'b1;
                        ctrl.link      = rt[4];
                        ctrl.reg_write = rt[4];
                        alu            = ALU_ADDU;
                    end
                    default: ;
                endcase
            end
            OP_J, OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.branch    = 1'b1;
                ctrl.link      = (opcode == OP_JAL);
                ctrl.reg_write = (opcode == OP_JAL);
                alu            = ALU_ADDU;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl.branch = 1'b1;
                alu         = ALU_ADDU;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                // Arithmetic and compare immediates sign-extend; logical ones zero-extend.
                case (opcode)
                    OP_ADDI:  begin alu = ALU_ADD;  ctrl.sign_or_zero = 1'b1; end
                    OP_ADDIU: begin alu = ALU_ADDU; ctrl.sign_or_zero = 1'b1; end
                    OP_SLTI:  begin alu = ALU_SLT;  ctrl.sign_or_zero = 1'b1; end
                    OP_SLTIU: begin alu = ALU_SLTU; ctrl.sign_or_zero = 1'b1; end
                    OP_ANDI:  alu = ALU_AND;
                    OP_ORI:   alu = ALU_OR;
                    OP_XORI:  alu = ALU_XOR;
                    default:  alu = ALU_LUI;
                endcase
            end
            OP_LW, OP_LB, OP_LBU, OP_LL: begin
                ctrl.mem_read     = 1'b1;
                ctrl.reg_write    = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.sign_or_zero = 1'b1;
                alu               = (opcode == OP_LL) ? ALU_LL : ALU_ADDU;
            end
            OP_SW, OP_SB, OP_SC: begin
                ctrl.mem_write    = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.sign_or_zero = 1'b1;
                ctrl.reg_write    = (opcode == OP_SC);
                alu               = (opcode == OP_SC) ? ALU_SC : ALU_ADDU;
            end
            default: ;
        endcase
    end

    assign Link         = ctrl.link;
    assign RegDest      = ctrl.reg_dest;
    assign Jump         = ctrl.jump;
    assign Branch       = ctrl.branch;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign ALUSrc       = ctrl.alu_src;
    assign RegWrite     = ctrl.reg_write;
    assign JumpRegister = ctrl.jump_register;
    assign SignOrZero   = ctrl.sign_or_zero;
    assign Syscall      = ctrl.syscall;
    assign ALUControl   = alu;

    assign DestReg = ctrl.reg_dest ? rd : (ctrl.link ? 5'd31 : rt);

    always_comb begin
        if (ctrl.jump && !ctrl.jump_register) begin
            NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
        end else if (ctrl.jump_register) begin
            NextInstructionAddress = JumpRegValue;
        end else begin
            NextInstructionAddress = Instr_PC_Plus4 + {{14{imm[15]}}, imm, 2'b00};
        end
    end

    id_regfile u_regfile (
        .CLK     (CLK),
        .RESET   (RESET),
        .rs_addr (rs),
        .rt_addr (rt),
        .rd_addr (DestReg),
        .wr_en   (Write),
        .wr_addr (WriteReg),
        .wr_data (WriteData),
        .rs_data (DataA),
        .rt_data (DataB),
        .rd_data (DataC)
    );

endmodule

`default_nettype wire

// File: tb/tb_id_decode_unit.sv
// ============================================================================
// tb_id_decode_unit -- directed and randomized checks against a table-driven model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_decode_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instr;
    logic [31:0] Instr_PC_Plus4;
    logic [31:0] JumpRegValue;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Write;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic [31:0] DataC;
    logic [4:0]  DestReg;
    logic [31:0] NextInstructionAddress;
    logic        Link, RegDest, Jump, Branch, MemRead, MemWrite;
    logic        ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
    logic [5:0]  ALUControl;

    id_decode_unit dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .Instr                  (Instr),
        .Instr_PC_Plus4         (Instr_PC_Plus4),
        .JumpRegValue           (JumpRegValue),
        .WriteReg               (WriteReg),
        .WriteData              (WriteData),
        .Write                  (Write),
        .DataA                  (DataA),
        .DataB                  (DataB),
        .DataC                  (DataC),
        .DestReg                (DestReg),
        .NextInstructionAddress (NextInstructionAddress),
        .Link                   (Link),
        .RegDest                (RegDest),
        .Jump                   (Jump),
        .Branch                 (Branch),
        .MemRead                (MemRead),
        .MemWrite               (MemWrite),
        .ALUSrc                 (ALUSrc),
        .RegWrite               (RegWrite),
        .JumpRegister           (JumpRegister),
        .SignOrZero             (SignOrZero),
        .Syscall                (Syscall),
        .ALUControl             (ALUControl)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Instruction table: opcode, which field selects the variant (0 none, 1 funct, 2 rt),
    // that field's value, ALU code and the flags set, one letter per flag.
    int          tab_n = 0;
    logic [5:0]  tab_op   [64];
    int          tab_kind [64];
    logic [5:0]  tab_key  [64];
    logic [5:0]  tab_alu  [64];
    string       tab_flags[64];

    logic [31:0] model_regs [32];

    task automatic add(input int op, input int kind, input int key, input int alu, input string fl);
        tab_op[tab_n]    = 6'(op);
        tab_kind[tab_n]  = kind;
        tab_key[tab_n]   = 6'(key);
        tab_alu[tab_n]   = 6'(alu);
        tab_flags[tab_n] = fl;
        tab_n++;
    endtask

    function automatic int lookup(input logic [31:0] ins);
        for (int i = 0; i < tab_n; i++) begin
            if (ins[31:26] == tab_op[i]) begin
                if (tab_kind[i] == 0) return i;
                if (tab_kind[i] == 1 && ins[5:0] == tab_key[i]) return i;
                if (tab_kind[i] == 2 && ins[20:16] == tab_key[i][4:0]) return i;
            end
        end
        return -1;
    endfunction

    // Flag vector order: Link RegDest Jump Branch MemRead MemWrite ALUSrc RegWrite JumpRegister SignOrZero Syscall
    function automatic logic [10:0] flags_of(input string fl);
        string      letters;
        logic [10:0] v;
        letters = "LDJBRMAWXSY";
        v = '0;
        for (int c = 0; c < fl.len(); c++) begin
            for (int j = 0; j < 11; j++) begin
                if (fl[c] == letters[j]) v[10-j] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (Write && WriteReg != 5'd0 && WriteReg == a) return WriteData;
        return model_regs[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc4, input logic [31:0] jrv,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        Instr          = ins;
        Instr_PC_Plus4 = pc4;
        JumpRegValue   = jrv;
        Write          = we;
        WriteReg       = wr;
        WriteData      = wd;
        #2;
    endtask

    task automatic clock_edge();
        @(posedge CLK);
        if (Write && WriteReg != 5'd0) model_regs[WriteReg] = WriteData;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    endtask

    task automatic check_all(input string tag);
        int          idx;
        logic [10:0] ef;
        logic [5:0]  ealu;
        logic [4:0]  edest;
        logic [31:0] enia;
        int          off;
        idx  = lookup(Instr);
        ef   = (idx < 0) ? 11'd0 : flags_of(tab_flags[idx]);
        ealu = (idx < 0) ? 6'd0  : tab_alu[idx];
        if (ef[9])       edest = Instr[15:11];
        else if (ef[10]) edest = 5'd31;
        else             edest = Instr[20:16];
        off = $signed(Instr[15:0]);
        if (ef[8] && !ef[2])  enia = (Instr_PC_Plus4 & 32'hF000_0000) | ({6'd0, Instr[25:0]} << 2);
        else if (ef[2])       enia = JumpRegValue;
        else                  enia = Instr_PC_Plus4 + 32'(off * 4);
        check({tag, " flags"}, {21'd0, Link, RegDest, Jump, Branch, MemRead, MemWrite,
                                 ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall}, {21'd0, ef});
        check({tag, " alu"},   {26'd0, ALUControl}, {26'd0, ealu});
        check({tag, " dest"},  {27'd0, DestReg}, {27'd0, edest});
        check({tag, " nia"},   NextInstructionAddress, enia);
        check({tag, " dataA"}, DataA, model_read(Instr[25:21]));
        check({tag, " dataB"}, DataB, model_read(Instr[20:16]));
        check({tag, " dataC"}, DataC, model_read(edest));
    endtask

    initial begin
        logic [31:0] ins;
        int          idx;
        logic [4:0]  wr;

        // R-type ALU ops: ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV
        add(0, 1, 32, 32, "DW"); add(0, 1, 33, 33, "DW"); add(0, 1, 34, 34, "DW");
        add(0, 1, 35, 35, "DW"); add(0, 1, 36, 36, "DW"); add(0, 1, 37, 37, "DW");
        add(0, 1, 38, 38, "DW"); add(0, 1, 39, 39, "DW"); add(0, 1, 42, 42, "DW");
        add(0, 1, 43, 43, "DW"); add(0, 1, 0, 0, "DW");   add(0, 1, 2, 2, "DW");
        add(0, 1, 3, 3, "DW");   add(0, 1, 4, 4, "DW");   add(0, 1, 6, 6, "DW");
        add(0, 1, 7, 7, "DW");
        add(0, 1, 8, 33, "JBX");          // JR
        add(0, 1, 9, 33, "LDJBXW");       // JALR
        add(0, 1, 12, 12, "Y");           // SYSCALL
        add(1, 2, 0, 33, "B");  add(1, 2, 1, 33, "B");          // BLTZ BGEZ
        add(1, 2, 16, 33, "LBW"); add(1, 2, 17, 33, "LBW");     // BLTZAL BGEZAL
        add(2, 0, 0, 33, "JB"); add(3, 0, 0, 33, "LJBW");       // J JAL
        add(4, 0, 0, 33, "B");  add(5, 0, 0, 33, "B");
        add(6, 0, 0, 33, "B");  add(7, 0, 0, 33, "B");
        add(8, 0, 0, 32, "AWS");  add(9, 0, 0, 33, "AWS");
        add(10, 0, 0, 42, "AWS"); add(11, 0, 0, 43, "AWS");
        add(12, 0, 0, 36, "AW");  add(13, 0, 0, 37, "AW");
        add(14, 0, 0, 38, "AW");  add(15, 0, 0, 15, "AW");
        add(32, 0, 0, 33, "RWAS"); add(35, 0, 0, 33, "RWAS"); add(36, 0, 0, 33, "RWAS");
        add(48, 0, 0, 40, "RWAS");                               // LL
        add(40, 0, 0, 33, "MAS");  add(43, 0, 0, 33, "MAS");     // SB SW
        add(56, 0, 0, 54, "MWAS");                               // SC

        // Reset pulse, released before the first clock edge.
        RESET = 1'b1;
        apply({6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        RESET = 1'b0;
        #1;
        clear_model();
        check("reset dataA", DataA, 32'd0);
        check("reset dataB", DataB, 32'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Write-through before the edge, then the stored value after it.
        apply({6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("bypass dataA", DataA, 32'hDEADBEEF);
        clock_edge();
        apply({6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("stored dataA", DataA, 32'hDEADBEEF);

        apply({6'd0, 5'd0, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("r0 bypass", DataA, 32'd0);
        clock_edge();
        apply({6'd0, 5'd0, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("r0 stored", DataA, 32'd0);

        apply({6'h04, 5'd0, 5'd0, 16'hFFFE}, 32'h00400010, 32'h0, 1'b0, 5'd0, 32'h0);
        check("beq nia", NextInstructionAddress, 32'h00400008);
        check("beq branch", {31'd0, Branch}, 32'd1);
        check("beq jump", {31'd0, Jump}, 32'd0);

        apply({6'h03, 26'h0100000}, 32'h00400004, 32'h0, 1'b0, 5'd0, 32'h0);
        check("jal nia", NextInstructionAddress, 32'h00400000);
        check("jal link/jump/regwrite", {29'd0, Link, Jump, RegWrite}, 32'd7);
        check("jal dest", {27'd0, DestReg}, 32'd31);

        apply({6'd0, 5'd5, 15'd0, 6'h08}, 32'h00400004, 32'h00001234, 1'b0, 5'd0, 32'h0);
        check("jr nia", NextInstructionAddress, 32'h00001234);
        check("jr jumpregister", {31'd0, JumpRegister}, 32'd1);

        apply({6'h0D, 5'd9, 5'd8, 16'h8000}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("ori signorzero/alusrc", {30'd0, SignOrZero, ALUSrc}, 32'd1);
        check("ori dest", {27'd0, DestReg}, 32'd8);
        check("ori alu", {26'd0, ALUControl}, 32'h25);

        apply({6'h30, 5'd1, 5'd2, 16'h0010}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("ll alu", {26'd0, ALUControl}, 32'h28);
        check("ll memread", {31'd0, MemRead}, 32'd1);

        apply({6'h38, 5'd1, 5'd2, 16'h0010}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("sc alu", {26'd0, ALUControl}, 32'h36);
        check("sc memwrite/regwrite", {30'd0, MemWrite, RegWrite}, 32'd3);

        apply(32'h0000000C, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("syscall", {31'd0, Syscall}, 32'd1);

        apply(32'h00000000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("nop regdest/regwrite", {30'd0, RegDest, RegWrite}, 32'd3);
        check("nop dest", {27'd0, DestReg}, 32'd0);

        // Randomized instructions, mostly legal encodings, with random writebacks.
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                idx = $urandom_range(0, tab_n - 1);
                ins[31:26] = tab_op[idx];
                if (tab_kind[idx] == 1) ins[5:0]   = tab_key[idx];
                if (tab_kind[idx] == 2) ins[20:16] = tab_key[idx][4:0];
            end
            wr = ($urandom_range(0, 3) == 0) ? ins[25:21] : 5'($urandom);
            apply(ins, $urandom, $urandom, 1'($urandom), wr, $urandom);
            check_all("rand");
            clock_edge();
        end

        // Asynchronous reset in the middle of a cycle clears stored state.
        apply({6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        clock_edge();
        apply({6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("pre-reset dataA", DataA, 32'hDEADBEEF);
        RESET = 1'b0;
        #1;
        clear_model();
        check("mid reset dataA", DataA, 32'd0);
        RESET = 1'b1;
        #1;
        check_all("post reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_decode_unit.md
Name: id_decode_unit

Overview:
- Combinational MIPS-I instruction decoder, branch/jump target calculator and 32x32 register file, merged into one decode-stage core.
- Sits inside the ID pipeline stage.
- The stage supplies the fetched instruction, its PC+4, a forwarded jump-register value and the writeback port.
- The block returns control flags, the ALU control code, the destination register, three register read values and the alternate PC.

Parameters:
- None. Fixed: 32 registers x 32 bits; register 0 reads as zero.

Ports:
- CLK  in  1  clock; register-file write edge is rising.
- RESET  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction being decoded.
- Instr_PC_Plus4  in  32  PC of Instr plus 4.
- JumpRegValue  in  32  (forwarded) rs value used for JR/JALR targets.
- WriteReg  in  5  writeback destination register.
- WriteData  in  32  writeback data.
- Write  in  1  writeback enable.
- DataA  out  32  value of rs (Instr[25:21]).
- DataB  out  32  value of rt (Instr[20:16]).
- DataC  out  32  value of DestReg (store data).
- DestReg  out  5  RegDest ? rd : (Link ? 31 : rt).
- NextInstructionAddress  out  32  branch/jump target.
- Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall  out  1 each  decode flags.
- ALUControl  out  6  ALU operation code.

Behaviour:
- Reset: all 32 registers are cleared to 0 asynchronously while RESET=0. All other outputs are combinational and take no reset value.
- Register write: on the rising CLK edge, if Write=1 and WriteReg!=0, then reg[WriteReg] <= WriteData. Writes to register 0 are ignored.
- Register read:
  - Reads are combinational. Register 0 always reads 0.
  - Write-through bypass: if Write=1, WriteReg!=0 and WriteReg equals a read address, that port returns WriteData in the same cycle.
- NextInstructionAddress, priority order:
  - Jump && !JumpRegister: {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00}.
  - JumpRegister: JumpRegValue.
  - Otherwise: Instr_PC_Plus4 + (sign-extended Instr[15:0] << 2), modulo 2^32.
- Decode, SPECIAL (opcode 0):
  - ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV: RegDest=1, RegWrite=1, ALUControl=funct.
  - JR: Jump=1, JumpRegister=1, Branch=1, ALUControl=100001.
  - JALR: as JR, plus Link=1, RegDest=1, RegWrite=1.
  - SYSCALL (funct 001100): Syscall=1, ALUControl=001100.
- Decode, I-type, ALUSrc=1, RegWrite=1:
  - ADDI 100000, ADDIU 100001, SLTI 101010, SLTIU 101011: SignOrZero=1.
  - ANDI 100100, ORI 100101, XORI 100110: SignOrZero=0.
  - LUI 001111.
- Decode, loads and stores:
  - LW/LB/LBU: MemRead=1, RegWrite=1, ALUSrc=1, SignOrZero=1, ALUControl=100001.
  - LL: as LW, ALUControl=101000.
  - SW/SB: MemWrite=1, ALUSrc=1, SignOrZero=1, ALUControl=100001.
  - SC: MemWrite=1, RegWrite=1, ALUSrc=1, SignOrZero=1, ALUControl=110110.
- Decode, branches: BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ set Branch=1, ALUControl=100001.
  - BLTZAL/BGEZAL: additionally Link=1, RegWrite=1.
- Decode, jumps:
  - J: Jump=1, Branch=1.
  - JAL: additionally Link=1, RegWrite=1.
  - Both: ALUControl=100001.
- Unrecognised opcode/funct: all flags 0, ALUControl=000000; the instruction acts as a NOP.
- Instruction 32'h0 decodes as SLL $0: RegDest=1, RegWrite=1, DestReg=0. The downstream stage suppresses writes to register 0.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants, funct constants, REGIMM rt codes;
  - ALUControl codes, including ALU_LL=6'b101000 and ALU_SC=6'b110110.
- One natural sub-module: id_regfile (storage, reset, write-through bypass).
- Decode and target calculation stay inline.

Test Plan:
- Reset, then write: pulse RESET low. Then Write=1, WriteReg=5, WriteData=32'hDEADBEEF, edge.
  - Rs=5 gives DataA=DEADBEEF.
  - Before that edge, rs=5 with the same write pending also gives DEADBEEF (bypass).
  - Reset mid-run clears it to 0.
- Register 0: write WriteReg=0, WriteData=FFFFFFFF -> DataA for rs=0 stays 0.
- BEQ with imm=16'hFFFE, Instr_PC_Plus4=32'h00400010 -> NextInstructionAddress=32'h00400008, Branch=1, Jump=0.
- JAL target 26'h0100000, PC+4=32'h00400004 -> NIA=32'h00400000, Link=1, Jump=1, DestReg=31, RegWrite=1.
- JR with JumpRegValue=32'h1234 -> NIA=32'h1234, JumpRegister=1.
- ORI $t0,$t1,0x8000 -> SignOrZero=0, ALUSrc=1, DestReg=8, ALUControl=100101.
- LL -> ALUControl=101000, MemRead=1.
- SC -> ALUControl=110110, MemWrite=1, RegWrite=1.
- SYSCALL (32'h0000000C) -> Syscall=1.
